trap_entry_sequencer: RTL

Writes the machine-mode trap state (mepc, mcause, optional mtval, mstatus) through the single CSR write port when the ID stage reports `ecall` or `unimp`. It then redirects fetch to mtvec. It is the entry-side counterpart of the mret return path, which reads mepc back. The block sits beside the CSR file. While it sequences the writes it stalls the pipeline, and it issues a one-cycle flush together with the redirect.

---
 rtl/trap_pkg.sv | 40 ++++
 rtl/mstatus_trap_update.sv | 18 +
 rtl/trap_entry_sequencer.sv | 137 +++++++++++++
 3 files changed

// File: rtl/trap_pkg.sv
// Shared trap-entry definitions: FSM states, CSR addresses, cause values,
// ID-stage trap codes and mstatus field positions.
package trap_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned CSR_AW = 12;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WR_MEPC    = 3'd1,
        ST_WR_MCAUSE  = 3'd2,
        ST_WR_MTVAL   = 3'd3,
        ST_WR_MSTATUS = 3'd4,
        ST_REDIRECT   = 3'd5
    } trap_state_e;

    localparam logic [CSR_AW-1:0] CSR_MSTATUS = 12'h300;
    localparam logic [CSR_AW-1:0] CSR_MEPC    = 12'h341;
    localparam logic [CSR_AW-1:0] CSR_MCAUSE  = 12'h342;
    localparam logic [CSR_AW-1:0] CSR_MTVAL   = 12'h343;

    localparam logic [XLEN-1:0] CAUSE_ECALL_M = 32'd11;
    localparam logic [XLEN-1:0] CAUSE_ILLEGAL = 32'd2;

    localparam logic [1:0] TRAP_NONE  = 2'b00;
    localparam logic [1:0] TRAP_ECALL = 2'b01;
    localparam logic [1:0] TRAP_UNIMP = 2'b10;
    localparam logic [1:0] TRAP_MRET  = 2'b11;

    localparam int unsigned MSTATUS_MIE    = 3;
    localparam int unsigned MSTATUS_MPIE   = 7;
    localparam int unsigned MSTATUS_MPP_LO = 11;
    localparam int unsigned MSTATUS_MPP_HI = 12;

    // Only ecall and unimp start a trap entry; none and mret are ignored.
    function automatic logic trap_accept(input logic [1:0] code);
        return (code == TRAP_ECALL) || (code == TRAP_UNIMP);
    endfunction

endpackage

// File: rtl/mstatus_trap_update.sv
// Combinational mstatus transform on machine trap entry:
// MPIE <- MIE, MIE <- 0, MPP <- M-mode, everything else unchanged.
module mstatus_trap_update
    import trap_pkg::*;
(
    input  logic [XLEN-1:0] mstatus_i,
    output logic [XLEN-1:0] mstatus_o
);

    // Apply the trap-entry field updates over a pass-through copy.
    always_comb begin
        mstatus_o                                = mstatus_i;
        mstatus_o[MSTATUS_MPIE]                  = mstatus_i[MSTATUS_MIE];
        mstatus_o[MSTATUS_MIE]                   = 1'b0;
        mstatus_o[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    end

endmodule

// File: rtl/trap_entry_sequencer.sv
// Machine-mode trap entry: writes mepc, mcause, (mtval), mstatus through the
// single CSR write port, then redirects fetch to mtvec with a one-cycle flush.
// Optional build macro: TRAP_MTVAL_EN adds the mtval write state.
module trap_entry_sequencer
    import trap_pkg::*;
(
    input  logic              clk,
    input  logic              rstn,
    input  logic [1:0]        trap,
    input  logic [XLEN-1:0]   trap_pc,
    input  logic [XLEN-1:0]   trap_inst,
    input  logic [XLEN-1:0]   csr_mtvec,
    input  logic [XLEN-1:0]   csr_mstatus,
    output logic              csr_we,
    output logic [CSR_AW-1:0] csr_waddr,
    output logic [XLEN-1:0]   csr_wdata,
    output logic              stall,
    output logic              flush,
    output logic              redirect_valid,
    output logic [XLEN-1:0]   redirect_pc,
    output logic              busy
);

    trap_state_e     state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [1:0]      code_q, code_d;
    logic [XLEN-1:0] mstatus_new;

`ifdef TRAP_MTVAL_EN
    logic [XLEN-1:0] inst_q, inst_d;
    logic            unused_inputs;
    assign unused_inputs = ^csr_mtvec[1:0];
`else
    logic            unused_inputs;
    assign unused_inputs = ^{trap_inst, csr_mtvec[1:0]};
`endif

    mstatus_trap_update u_mstatus_upd (
        .mstatus_i (csr_mstatus),
        .mstatus_o (mstatus_new)
    );

    // State and trap-latch registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            code_q  <= TRAP_NONE;
`ifdef TRAP_MTVAL_EN
            inst_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            code_q  <= code_d;
`ifdef TRAP_MTVAL_EN
            inst_q  <= inst_d;
`endif
        end
    end

    // Next-state, latch capture and per-state CSR/pipeline control.
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        code_d         = code_q;
`ifdef TRAP_MTVAL_EN
        inst_d         = inst_q;
`endif
        csr_we         = 1'b0;
        csr_waddr      = '0;
        csr_wdata      = '0;
        stall          = 1'b0;
        flush          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        busy           = (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                if (trap_accept(trap)) begin
                    stall   = 1'b1;
                    pc_d    = trap_pc;
                    code_d  = trap;
`ifdef TRAP_MTVAL_EN
                    inst_d  = trap_inst;
`endif
                    state_d = ST_WR_MEPC;
                end
            end
            ST_WR_MEPC: begin
                csr_we    = 1'b1;
                csr_waddr = CSR_MEPC;
                csr_wdata = pc_q;
                stall     = 1'b1;
                state_d   = ST_WR_MCAUSE;
            end
            ST_WR_MCAUSE: begin
                csr_we    = 1'b1;
                csr_waddr = CSR_MCAUSE;
                csr_wdata = (code_q == TRAP_ECALL) ? CAUSE_ECALL_M : CAUSE_ILLEGAL;
                stall     = 1'b1;
`ifdef TRAP_MTVAL_EN
                state_d   = ST_WR_MTVAL;
`else
                state_d   = ST_WR_MSTATUS;
`endif
            end
`ifdef TRAP_MTVAL_EN
            ST_WR_MTVAL: begin
                csr_we    = 1'b1;
                csr_waddr = CSR_MTVAL;
                csr_wdata = (code_q == TRAP_UNIMP) ? inst_q : '0;
                stall     = 1'b1;
                state_d   = ST_WR_MSTATUS;
            end
`endif
            ST_WR_MSTATUS: begin
                csr_we    = 1'b1;
                csr_waddr = CSR_MSTATUS;
                csr_wdata = mstatus_new;
                stall     = 1'b1;
                state_d   = ST_REDIRECT;
            end
            ST_REDIRECT: begin
                flush          = 1'b1;
                redirect_valid = 1'b1;
                redirect_pc    = {csr_mtvec[XLEN-1:2], 2'b00};
                state_d        = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule
